// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller with a start/stop button and a lap/clear button.
// A prescaler divides clk down to count ticks. Each tick advances a
// multi-digit BCD count. A lap display freezes the visible value while
// counting continues underneath.
module stopwatch_lap_ctrl #(
    parameter int CLK_DIV        = 100000,
    parameter int NUM_DIGITS     = 4,
    parameter int ACTIVE_LOW_BTN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start_btn,
    input  logic                      lap_btn,
    output logic [1:0]                state,
    output logic                      run,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic [4*NUM_DIGITS-1:0]   disp,
    output logic                      tick,
    output logic                      wrap
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int CW = 4 * NUM_DIGITS;

    localparam logic [1:0]    S_IDLE  = 2'b00;
    localparam logic [1:0]    S_RUN   = 2'b01;
    localparam logic [1:0]    S_PAUSE = 2'b10;
    localparam logic [1:0]    S_LAP   = 2'b11;

    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
    localparam logic [CW-1:0] COUNT_ZERO = CW'(0);

    // Button pipelines carry the "pressed" level, not the raw pin level.
    logic [1:0]    r_start_sync;
    logic [1:0]    r_lap_sync;
    logic          r_start_prev;
    logic          r_lap_prev;

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_disp;

    logic          w_start_lvl;
    logic          w_lap_lvl;
    logic          w_start_press;
    logic          w_lap_press;
    logic [1:0]    w_state_next;
    logic          w_clear;
    logic          w_counting;
    logic          w_tick;
    logic [CW-1:0] w_count_inc;
    logic          w_all_nines;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_presc_next;
    logic [CW-1:0] w_disp_next;

    assign w_start_lvl = (ACTIVE_LOW_BTN != 0) ? ~start_btn : start_btn;
    assign w_lap_lvl   = (ACTIVE_LOW_BTN != 0) ? ~lap_btn   : lap_btn;

    // Synchronise both buttons and keep the previous level for edge detection.
    // Reset loads "pressed" so a button held through reset gives no event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_start_sync <= 2'b11;
            r_lap_sync   <= 2'b11;
            r_start_prev <= 1'b1;
            r_lap_prev   <= 1'b1;
        end else begin
            r_start_sync <= {r_start_sync[0], w_start_lvl};
            r_lap_sync   <= {r_lap_sync[0], w_lap_lvl};
            r_start_prev <= r_start_sync[1];
            r_lap_prev   <= r_lap_sync[1];
        end
    end

    assign w_start_press = r_start_sync[1] & ~r_start_prev;
    assign w_lap_press   = r_lap_sync[1] & ~r_lap_prev;

    // Next-state logic. A start press wins, and a lap press in the same cycle is dropped.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_press) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_start_press) begin
                    w_state_next = S_PAUSE;
                end else if (w_lap_press) begin
                    w_state_next = S_LAP;
                end else begin
                    w_state_next = S_RUN;
                end
            end
            S_LAP: begin
                if (w_start_press) begin
                    w_state_next = S_PAUSE;
                end else if (w_lap_press) begin
                    w_state_next = S_RUN;
                end else begin
                    w_state_next = S_LAP;
                end
            end
            S_PAUSE: begin
                if (w_start_press) begin
                    w_state_next = S_RUN;
                end else if (w_lap_press) begin
                    w_state_next = S_IDLE;
                    w_clear      = 1'b1;
                end else begin
                    w_state_next = S_PAUSE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_clear      = 1'b0;
            end
        endcase
    end

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == PRESC_MAX);

    // BCD ripple increment. A carry out of the top digit means every digit was 9.
    always_comb begin
        logic v_carry;
        v_carry     = 1'b1;
        w_count_inc = r_count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                    v_carry               = 1'b1;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    v_carry               = 1'b0;
                end
            end else begin
                w_count_inc[4*i +: 4] = r_count[4*i +: 4];
            end
        end
        w_all_nines = v_carry;
    end

    // Next count, prescaler and display. PAUSE keeps the partial interval, and IDLE clears it.
    always_comb begin
        w_count_next = r_count;
        w_presc_next = r_presc;
        w_disp_next  = r_disp;
        if (w_clear) begin
            w_count_next = COUNT_ZERO;
            w_presc_next = PRESC_ZERO;
        end else if (w_counting) begin
            w_count_next = w_tick ? w_count_inc : r_count;
            w_presc_next = w_tick ? PRESC_ZERO : (r_presc + PRESC_ONE);
        end else if (r_state == S_IDLE) begin
            w_count_next = r_count;
            w_presc_next = PRESC_ZERO;
        end else begin
            w_count_next = r_count;
            w_presc_next = r_presc;
        end
        if (w_state_next == S_LAP) begin
            w_disp_next = (r_state == S_LAP) ? r_disp : r_count;
        end else begin
            w_disp_next = w_count_next;
        end
    end

    // Main state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_presc <= PRESC_ZERO;
            r_count <= COUNT_ZERO;
            r_disp  <= COUNT_ZERO;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_count <= w_count_next;
            r_disp  <= w_disp_next;
        end
    end

    assign state = r_state;
    assign run   = w_counting;
    assign count = r_count;
    assign disp  = r_disp;
    assign tick  = w_tick;
    assign wrap  = w_tick & w_all_nines;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Randomised bench for stopwatch_lap_ctrl. It compares the DUT with a
// decimal-arithmetic reference model every cycle.
module tb_stopwatch_lap_ctrl;

    localparam int CLK_DIV = 4;
    localparam int ND      = 2;
    localparam int ALB     = 1;
    localparam int CW      = 4 * ND;
    localparam int MAXV    = 100;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_btn;
    logic          lap_btn;
    logic [1:0]    state;
    logic          run;
    logic [CW-1:0] count;
    logic [CW-1:0] disp;
    logic          tick;
    logic          wrap;

    stopwatch_lap_ctrl #(
        .CLK_DIV(CLK_DIV), .NUM_DIGITS(ND), .ACTIVE_LOW_BTN(ALB)
    ) dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .lap_btn(lap_btn),
        .state(state), .run(run), .count(count), .disp(disp),
        .tick(tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model. State: 0 idle, 1 run, 2 pause, 3 lap.
    // Count and display are kept as plain integers.
    int       m_state, m_count, m_disp, m_presc;
    bit [2:0] m_hs, m_hl;   // pressed-level history, bit 0 newest
    int       m_wraps, d_wraps;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = 32'd0;
        t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit counting(input int s);
        return (s == 1) || (s == 3);
    endfunction

    task automatic model_step();
        bit ps, pl, ps_lvl, pl_lvl, tk;
        int ns, old_count;
        ps_lvl = (ALB != 0) ? !start_btn : start_btn;
        pl_lvl = (ALB != 0) ? !lap_btn : lap_btn;
        if (reset) begin
            m_state = 0; m_count = 0; m_disp = 0; m_presc = 0;
            m_hs = 3'b111; m_hl = 3'b111;
        end else begin
            // A press is a level that was newly seen two edges ago.
            ps = m_hs[1] && !m_hs[2];
            pl = m_hl[1] && !m_hl[2];
            tk = counting(m_state) && (m_presc == CLK_DIV - 1);
            old_count = m_count;
            if (tk) m_count = (m_count + 1) % MAXV;
            if (counting(m_state)) m_presc = (m_presc + 1) % CLK_DIV;
            else if (m_state == 0) m_presc = 0;
            ns = m_state;
            case (m_state)
                0: if (ps) ns = 1;
                1: if (ps) ns = 2; else if (pl) ns = 3;
                3: if (ps) ns = 2; else if (pl) ns = 1;
                2: if (ps) ns = 1;
                   else if (pl) begin ns = 0; m_count = 0; m_presc = 0; end
                default: ns = 0;
            endcase
            if (ns == 3) begin
                if (m_state != 3) m_disp = old_count;
            end else begin
                m_disp = m_count;
            end
            m_state = ns;
            m_hs = {m_hs[1:0], ps_lvl};
            m_hl = {m_hl[1:0], pl_lvl};
        end
    endtask

    task automatic compare_all();
        bit etk, ewr;
        etk = counting(m_state) && (m_presc == CLK_DIV - 1);
        ewr = etk && (m_count == MAXV - 1);
        if (ewr) m_wraps++;
        if (wrap === 1'b1) d_wraps++;
        check_val("state", 32'(state), 32'(m_state));
        check_val("run",   32'(run),   32'(counting(m_state)));
        check_val("count", 32'(count), to_bcd(m_count));
        check_val("disp",  32'(disp),  to_bcd(m_disp));
        check_val("tick",  32'(tick),  32'(etk));
        check_val("wrap",  32'(wrap),  32'(ewr));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    endtask

    initial begin
        m_state = 0; m_count = 0; m_disp = 0; m_presc = 0;
        m_hs = 3'b111; m_hl = 3'b111; m_wraps = 0; d_wraps = 0;
        reset = 1'b1; start_btn = 1'b1; lap_btn = 1'b1;
        step(3);
        check_val("reset_state", 32'(state), 32'd0);
        reset = 1'b0;
        step(2);

        // Start, then free-run past 99 so that a rollover happens.
        start_btn = 1'b0; step(1);
        start_btn = 1'b1; step(2);
        check_val("start_run", 32'(state), 32'd1);
        step(420);
        check_val("wrap_count", 32'(d_wraps), 32'(m_wraps));

        // Random button activity with occasional resets.
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(11, 0) == 0) start_btn = ~start_btn;
            if ($urandom_range(9, 0) == 0)  lap_btn   = ~lap_btn;
            reset = ($urandom_range(699, 0) == 0);
            step(1);
        end
        reset = 1'b0; start_btn = 1'b1; lap_btn = 1'b1;
        step(4);

        // A start button held through reset must not start the watch.
        start_btn = 1'b0; reset = 1'b1;
        step(3);
        reset = 1'b0;
        step(6);
        check_val("hold_rst", 32'(state), 32'd0);
        start_btn = 1'b1;
        step(4);
        check_val("hold_rel", 32'(state), 32'd0);

        // Both buttons pressed together in RUN: start wins.
        start_btn = 1'b0; step(1);
        start_btn = 1'b1; step(6);
        check_val("simul_pre", 32'(state), 32'd1);
        start_btn = 1'b0; lap_btn = 1'b0; step(1);
        start_btn = 1'b1; lap_btn = 1'b1; step(4);
        check_val("simul_state", 32'(state), 32'd2);
        check_val("simul_disp", 32'(disp), to_bcd(m_count));

        // Reset asserted in RUN clears everything at the next edge.
        start_btn = 1'b0; step(1);
        start_btn = 1'b1; step(9);
        reset = 1'b1; step(1);
        check_val("midrun_rst", {state, run, tick, wrap, count, disp}, 32'd0);
        reset = 1'b0; step(2);

        check_val("wrap_total", 32'(d_wraps), 32'(m_wraps));
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
